// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multicycle MIPS datapath: fetch/decode/execute/mem/writeback with memory-ready stalls.
// Define MC_JUMP_EN to add the j (opcode 000010) path through the JUMP state; otherwise j decodes as illegal.
module multicycle_control_fsm #(
    parameter int WAIT_CNT_W = 8,
    parameter int WAIT_LIMIT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] state_dbg
);
    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [WAIT_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0] CNT_LIMIT = WAIT_CNT_W'(WAIT_LIMIT);
    localparam logic                  LIMIT_EN  = (WAIT_LIMIT != 0);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    bus_error_q, bus_error_d;
    logic [WAIT_CNT_W-1:0]   cnt_inc;
    logic                    stall_timeout;

    assign cnt_inc       = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_ONE;
    // A ready on the limit cycle takes priority, so the timeout requires mem_ready low.
    assign stall_timeout = LIMIT_EN && (wait_cnt_q == CNT_LIMIT) && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        bus_error_d   = bus_error_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (stall_timeout) begin
                    state_d     = S_ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wait_cnt_d = cnt_inc;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (stall_timeout) begin
                    state_d     = S_ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wait_cnt_d = cnt_inc;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (stall_timeout) begin
                    state_d     = S_ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wait_cnt_d = cnt_inc;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
`endif
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_RST;
        endcase
    end

    assign bus_error = bus_error_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class, stalls, timeout and reset.
module tb_multicycle_control_fsm;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, bus_error;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.WAIT_CNT_W(8), .WAIT_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal_op(illegal_op), .bus_error(bus_error), .state_dbg(state_dbg)
    );

    // Field order: pc_write, pc_write_cond, pc_source[2], i_or_d, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], illegal_op, bus_error
    logic [17:0] outs;
    assign outs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, bus_error};

    localparam logic [17:0] E_ZERO       = 18'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] E_FETCH_STL  = 18'b0_0_00_0_1_0_0_0_0_0_0_01_00_0_0;
    localparam logic [17:0] E_FETCH_RDY  = 18'b1_0_00_0_1_0_1_0_0_0_0_01_00_0_0;
    localparam logic [17:0] E_DECODE     = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_0;
    localparam logic [17:0] E_DECODE_ILL = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_1_0;
    localparam logic [17:0] E_MEMADR     = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [17:0] E_MEMRD      = 18'b0_0_00_1_1_0_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] E_MEMWB      = 18'b0_0_00_0_0_0_0_1_0_1_0_00_00_0_0;
    localparam logic [17:0] E_MEMWR      = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] E_EXEC       = 18'b0_0_00_0_0_0_0_0_0_0_1_00_10_0_0;
    localparam logic [17:0] E_ALUWB      = 18'b0_0_00_0_0_0_0_0_1_1_0_00_00_0_0;
    localparam logic [17:0] E_BRANCH     = 18'b0_1_01_0_0_0_0_0_0_0_1_00_01_0_0;
    localparam logic [17:0] E_ERROR      = 18'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_1;
`ifdef MC_JUMP_EN
    localparam logic [17:0] E_JUMP       = 18'b1_0_10_0_0_0_0_0_0_0_0_00_00_0_0;
`endif

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // Called at posedge+1: apply inputs, sample mid-cycle, then advance to the next posedge+1.
    task automatic step(input string tag, input logic [5:0] opc, input logic rdy,
                        input logic [3:0] exp_st, input logic [17:0] exp_o);
        opcode    = opc;
        mem_ready = rdy;
        #2;
        checks++;
        assert (state_dbg === exp_st) else begin
            failures++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state_dbg, exp_st);
        end
        checks++;
        assert (outs === exp_o) else begin
            failures++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, outs, exp_o);
        end
        $display("step %-12s opcode=%b ready=%b state=%0d outs=%b", tag, opc, rdy, state_dbg, outs);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("rst_hold", OP_R, 1'b1, 4'd0, E_ZERO);
        rst_n = 1'b1;
        step("rst_rel", OP_R, 1'b1, 4'd0, E_ZERO);

        // R-type: 1,2,7,8 then back to 1
        step("r_fetch", OP_R, 1'b1, 4'd1, E_FETCH_RDY);
        step("r_decode", OP_R, 1'b1, 4'd2, E_DECODE);
        step("r_exec", OP_R, 1'b1, 4'd7, E_EXEC);
        step("r_aluwb", OP_R, 1'b1, 4'd8, E_ALUWB);

        // lw with a one-cycle fetch stall, then three MEMRD stalls
        step("lw_fstall", OP_LW, 1'b0, 4'd1, E_FETCH_STL);
        step("lw_fetch", OP_LW, 1'b1, 4'd1, E_FETCH_RDY);
        step("lw_decode", OP_LW, 1'b1, 4'd2, E_DECODE);
        step("lw_memadr", OP_LW, 1'b1, 4'd3, E_MEMADR);
        step("lw_rdstl0", OP_LW, 1'b0, 4'd4, E_MEMRD);
        step("lw_rdstl1", OP_LW, 1'b0, 4'd4, E_MEMRD);
        step("lw_rdstl2", OP_LW, 1'b0, 4'd4, E_MEMRD);
        step("lw_memrd", OP_LW, 1'b1, 4'd4, E_MEMRD);
        step("lw_memwb", OP_LW, 1'b1, 4'd5, E_MEMWB);

        // sw with one write stall
        step("sw_fetch", OP_SW, 1'b1, 4'd1, E_FETCH_RDY);
        step("sw_decode", OP_SW, 1'b1, 4'd2, E_DECODE);
        step("sw_memadr", OP_SW, 1'b1, 4'd3, E_MEMADR);
        step("sw_wrstl", OP_SW, 1'b0, 4'd6, E_MEMWR);
        step("sw_memwr", OP_SW, 1'b1, 4'd6, E_MEMWR);

        // beq
        step("beq_fetch", OP_BEQ, 1'b1, 4'd1, E_FETCH_RDY);
        step("beq_decode", OP_BEQ, 1'b1, 4'd2, E_DECODE);
        step("beq_branch", OP_BEQ, 1'b1, 4'd9, E_BRANCH);

        // Illegal opcode: single pulse then back to FETCH
        step("ill_fetch", OP_BAD, 1'b1, 4'd1, E_FETCH_RDY);
        step("ill_decode", OP_BAD, 1'b1, 4'd2, E_DECODE_ILL);
        step("ill_back", OP_BAD, 1'b0, 4'd1, E_FETCH_STL);
        // counter now 1; stall until it reaches the limit, then ready wins
        step("lim_stl1", OP_BEQ, 1'b0, 4'd1, E_FETCH_STL);
        step("lim_stl2", OP_BEQ, 1'b0, 4'd1, E_FETCH_STL);
        step("lim_stl3", OP_BEQ, 1'b0, 4'd1, E_FETCH_STL);
        step("lim_ready", OP_BEQ, 1'b1, 4'd1, E_FETCH_RDY);
        step("lim_decode", OP_BEQ, 1'b1, 4'd2, E_DECODE);
        step("lim_branch", OP_BEQ, 1'b1, 4'd9, E_BRANCH);

        // Timeout: counter 0..3 stalls, then at 4 with ready low -> ERROR
        for (int i = 0; i < 5; i++) begin
            step($sformatf("to_stl%0d", i), OP_R, 1'b0, 4'd1, E_FETCH_STL);
        end
        step("err_hold0", OP_R, 1'b0, 4'd15, E_ERROR);
        step("err_hold1", OP_R, 1'b1, 4'd15, E_ERROR);
        rst_n = 1'b0;
        step("err_rst", OP_R, 1'b1, 4'd15, E_ERROR);
        step("err_clr", OP_R, 1'b1, 4'd0, E_ZERO);
        rst_n = 1'b1;
        step("post_rst", OP_R, 1'b1, 4'd0, E_ZERO);

        // Jump opcode
        step("j_fetch", OP_J, 1'b1, 4'd1, E_FETCH_RDY);
`ifdef MC_JUMP_EN
        step("j_decode", OP_J, 1'b1, 4'd2, E_DECODE);
        step("j_jump", OP_J, 1'b1, 4'd10, E_JUMP);
`else
        step("j_decode", OP_J, 1'b1, 4'd2, E_DECODE_ILL);
`endif
        step("j_back", OP_J, 1'b0, 4'd1, E_FETCH_STL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
